rr_arbiter_n: RTL and testbench

//  N-input round-robin output-port arbiter for the NoC router; successor of the fixed 5-port arbiter.

---
 rtl/rr_arbiter_n.sv | 169 ++++++++++++++++
 tb/tb_rr_arbiter_n.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-input round-robin output-port arbiter for one NoC router output.
// Grants one input per flit on the downstream RTS/DCTS link and drives the crossbar select.
// Optional packet locking is enabled by defining ARB_PKT_LOCK_EN (adds the tail port).
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous reset, active-low
//   req       per-input request, held until the matching grant
//   dcts      downstream clear-to-send
//   tail      tail-flit marker qualified by grant (ARB_PKT_LOCK_EN only)
//   grant     one-hot flit-transfer pulse = onehot(owner) & {rts & dcts}
//   xbar_sel  one-hot crossbar select for the owner, 0 in IDLE (registered)
//   rts       request-to-send (registered)
module rr_arbiter_n #(
  parameter int unsigned NUM_PORTS = 5,
  parameter bit          STICKY    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 dcts,
`ifdef ARB_PKT_LOCK_EN
  input  logic [NUM_PORTS-1:0] tail,
`endif
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] xbar_sel,
  output logic                 rts
);

  localparam int unsigned PW = $clog2(NUM_PORTS);
  // One extra bit so ptr + offset (< 2*NUM_PORTS) never overflows before the wrap.
  localparam int unsigned SW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 rts_q, rts_d;
  logic [NUM_PORTS-1:0] xbar_sel_q, xbar_sel_d;
`ifdef ARB_PKT_LOCK_EN
  logic                 locked_q, locked_d;
`endif

  logic [PW-1:0]        scan_idx;
  logic                 scan_found;
  logic [SW-1:0]        scan_sum;
  logic [PW-1:0]        winner;
  logic                 xfer;

  // Round-robin scan starting at ptr+1 with explicit wrap, so indices >= NUM_PORTS never occur.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    scan_sum   = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      scan_sum = SW'(ptr_q) + SW'(i);
      if (scan_sum >= SW'(NUM_PORTS)) begin
        scan_sum = scan_sum - SW'(NUM_PORTS);
      end
      if (!scan_found && req[PW'(scan_sum)]) begin
        scan_found = 1'b1;
        scan_idx   = PW'(scan_sum);
      end
    end
  end

  // Sticky mode lets the current owner keep the port while it still requests.
  always_comb begin
    winner = scan_idx;
    if (STICKY && req[owner_q]) begin
      winner = owner_q;
    end
  end

  // A flit moves only in ACTIVE (rts high) with dcts; xbar_sel holds onehot(owner) there.
  assign xfer     = rts_q & dcts;
  assign grant    = xbar_sel_q & {NUM_PORTS{xfer}};
  assign xbar_sel = xbar_sel_q;
  assign rts      = rts_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef ARB_PKT_LOCK_EN
    locked_d = locked_q;
`endif
    rts_d      = 1'b0;
    xbar_sel_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d = winner;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (dcts) begin
          ptr_d   = owner_q;
          state_d = ST_GAP;
`ifdef ARB_PKT_LOCK_EN
          locked_d = ~tail[owner_q];
`endif
        end
      end
      ST_GAP: begin
`ifdef ARB_PKT_LOCK_EN
        if (locked_q) begin
          // Mid-packet: only the owner may continue; wait in GAP until it requests again.
          if (req[owner_q]) begin
            state_d = ST_ACTIVE;
          end
        end else if (|req) begin
          owner_d = winner;
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
`else
        if (|req) begin
          owner_d = winner;
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rts_d = (state_d == ST_ACTIVE);
    if (state_d != ST_IDLE) begin
      xbar_sel_d[owner_d] = 1'b1;
    end
  end

  // State and output registers; reset clears all outputs immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      ptr_q      <= PW'(NUM_PORTS - 1);
      rts_q      <= 1'b0;
      xbar_sel_q <= '0;
`ifdef ARB_PKT_LOCK_EN
      locked_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      rts_q      <= rts_d;
      xbar_sel_q <= xbar_sel_d;
`ifdef ARB_PKT_LOCK_EN
      locked_q   <= locked_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Self-checking bench for rr_arbiter_n (NUM_PORTS=5): one sticky and one rotating instance.
module tb_rr_arbiter_n;

  logic       clk;
  logic       rst;
  logic [4:0] req_s, req_r;
  logic       dcts;
`ifdef ARB_PKT_LOCK_EN
  logic [4:0] tail;
`endif
  logic [4:0] grant_s, xbar_s, grant_r, xbar_r;
  logic       rts_s, rts_r;

  int errors = 0;
  int checks = 0;

  rr_arbiter_n #(.NUM_PORTS(5), .STICKY(1'b1)) dut_s (
    .clk(clk), .rst(rst), .req(req_s), .dcts(dcts),
`ifdef ARB_PKT_LOCK_EN
    .tail(tail),
`endif
    .grant(grant_s), .xbar_sel(xbar_s), .rts(rts_s)
  );

  rr_arbiter_n #(.NUM_PORTS(5), .STICKY(1'b0)) dut_r (
    .clk(clk), .rst(rst), .req(req_r), .dcts(dcts),
`ifdef ARB_PKT_LOCK_EN
    .tail(tail),
`endif
    .grant(grant_r), .xbar_sel(xbar_r), .rts(rts_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         use_r;
    bit         rst_n;
    logic [4:0] req;
    bit         dcts;
    bit         exp_rts;
    logic [4:0] exp_grant;
    logic [4:0] exp_xbar;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int step, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, step, act, exp);
    end
  endtask

  // Drive at the falling edge, then sample 1 time unit later (well away from the rising edge).
  task automatic drive(input bit r, input logic [4:0] rs, input logic [4:0] rr, input bit d);
    @(negedge clk);
    rst   = r;
    req_s = rs;
    req_r = rr;
    dcts  = d;
`ifdef ARB_PKT_LOCK_EN
    tail  = 5'b0;
`endif
    #1;
  endtask

  task automatic add(input bit u, input bit r, input logic [4:0] q, input bit d,
                     input bit er, input logic [4:0] eg, input logic [4:0] ex);
    vecs.push_back('{u, r, q, d, er, eg, ex});
  endtask

  initial begin
    rst = 1'b0; req_s = '0; req_r = '0; dcts = 1'b0;
`ifdef ARB_PKT_LOCK_EN
    tail = '0;
`endif

    // Single requester on the sticky instance.
    add(0, 0, 5'b00000, 0, 0, 5'b00000, 5'b00000);
    add(0, 1, 5'b00100, 1, 0, 5'b00000, 5'b00000);
    add(0, 1, 5'b00100, 1, 1, 5'b00100, 5'b00100);
    add(0, 1, 5'b00000, 1, 0, 5'b00000, 5'b00100);
    add(0, 1, 5'b00000, 1, 0, 5'b00000, 5'b00000);
    // Rotating instance, all ports requesting: one grant every two cycles, wrapping 4 -> 0.
    add(1, 0, 5'b00000, 0, 0, 5'b00000, 5'b00000);
    add(1, 1, 5'b11111, 1, 0, 5'b00000, 5'b00000);
    add(1, 1, 5'b11111, 1, 1, 5'b00001, 5'b00001);
    add(1, 1, 5'b11111, 1, 0, 5'b00000, 5'b00001);
    add(1, 1, 5'b11111, 1, 1, 5'b00010, 5'b00010);
    add(1, 1, 5'b11111, 1, 0, 5'b00000, 5'b00010);
    add(1, 1, 5'b11111, 1, 1, 5'b00100, 5'b00100);
    add(1, 1, 5'b11111, 1, 0, 5'b00000, 5'b00100);
    add(1, 1, 5'b11111, 1, 1, 5'b01000, 5'b01000);
    add(1, 1, 5'b11111, 1, 0, 5'b00000, 5'b01000);
    add(1, 1, 5'b11111, 1, 1, 5'b10000, 5'b10000);
    add(1, 1, 5'b11111, 1, 0, 5'b00000, 5'b10000);
    add(1, 1, 5'b11111, 1, 1, 5'b00001, 5'b00001);
    // Sticky instance keeps port 0 while it requests; dropping req[0] hands over to port 1.
    add(0, 0, 5'b00000, 0, 0, 5'b00000, 5'b00000);
    add(0, 1, 5'b00011, 1, 0, 5'b00000, 5'b00000);
    add(0, 1, 5'b00011, 1, 1, 5'b00001, 5'b00001);
    add(0, 1, 5'b00011, 1, 0, 5'b00000, 5'b00001);
    add(0, 1, 5'b00011, 1, 1, 5'b00001, 5'b00001);
    add(0, 1, 5'b00010, 1, 0, 5'b00000, 5'b00001);
    add(0, 1, 5'b00010, 1, 1, 5'b00010, 5'b00010);

    foreach (vecs[i]) begin
      if (vecs[i].use_r) begin
        drive(vecs[i].rst_n, 5'b0, vecs[i].req, vecs[i].dcts);
        check("tbl_rts",   i, {4'b0, rts_r}, {4'b0, vecs[i].exp_rts});
        check("tbl_grant", i, grant_r, vecs[i].exp_grant);
        check("tbl_xbar",  i, xbar_r,  vecs[i].exp_xbar);
      end else begin
        drive(vecs[i].rst_n, vecs[i].req, 5'b0, vecs[i].dcts);
        check("tbl_rts",   i, {4'b0, rts_s}, {4'b0, vecs[i].exp_rts});
        check("tbl_grant", i, grant_s, vecs[i].exp_grant);
        check("tbl_xbar",  i, xbar_s,  vecs[i].exp_xbar);
      end
    end

    // Owner 3 stalled by dcts=0 for 5 cycles, then granted; dcts ignored in GAP and IDLE.
    drive(0, 5'b0, 5'b0, 0);
    drive(1, 5'b01000, 5'b0, 0);
    check("stall_idle_rts", 0, {4'b0, rts_s}, 5'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 5'b01000, 5'b0, 0);
      check("stall_rts",   k, {4'b0, rts_s}, 5'b00001);
      check("stall_grant", k, grant_s, 5'b00000);
      check("stall_xbar",  k, xbar_s,  5'b01000);
    end
    drive(1, 5'b01000, 5'b0, 1);
    check("stall_release_grant", 0, grant_s, 5'b01000);
    drive(1, 5'b0, 5'b0, 1);
    check("gap_rts",   0, {4'b0, rts_s}, 5'b0);
    check("gap_grant", 0, grant_s, 5'b0);
    drive(1, 5'b0, 5'b0, 1);
    check("idle_grant", 0, grant_s, 5'b0);
    check("idle_xbar",  0, xbar_s,  5'b0);

    // Asynchronous reset in the middle of ACTIVE drops every output before the next edge.
    drive(0, 5'b0, 5'b0, 0);
    drive(1, 5'b00100, 5'b0, 0);
    drive(1, 5'b00100, 5'b0, 0);
    check("prerst_rts", 0, {4'b0, rts_s}, 5'b00001);
    @(posedge clk);
    #2;
    dcts = 1'b1;
    #1;
    check("prerst_grant", 0, grant_s, 5'b00100);
    rst = 1'b0;
    #1;
    check("async_rst_rts",   0, {4'b0, rts_s}, 5'b0);
    check("async_rst_grant", 0, grant_s, 5'b0);
    check("async_rst_xbar",  0, xbar_s,  5'b0);
    drive(1, 5'b10001, 5'b0, 1);
    check("postrst_idle_rts", 0, {4'b0, rts_s}, 5'b0);
    drive(1, 5'b10001, 5'b0, 1);
    check("postrst_grant", 0, grant_s, 5'b00001);

`ifdef ARB_PKT_LOCK_EN
    // Port 0 locks the rotating instance for a 3-flit packet; port 1 follows the tail.
    drive(0, 5'b0, 5'b0, 0);
    drive(1, 5'b0, 5'b00011, 1);
    check("lock_idle_rts", 0, {4'b0, rts_r}, 5'b0);
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      tail = (f == 2) ? 5'b00001 : 5'b00000;
      #1;
      check("lock_grant", f, grant_r, 5'b00001);
      drive(1, 5'b0, 5'b00011, 1);
      check("lock_gap_rts", f, {4'b0, rts_r}, 5'b0);
    end
    drive(1, 5'b0, 5'b00011, 1);
    check("lock_release_grant", 0, grant_r, 5'b00010);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
